// File: rtl/cache_refill_buffer_pkg.sv
// Shared cache refill constants, refill state encoding and line-alignment helper.
package cache_refill_buffer_pkg;

  localparam int ADDR_W   = 32;
  localparam int LINE_W   = 512;
  localparam int BEAT_W   = 64;
  localparam int INDEX_W  = 6;
  localparam int OFFSET_W = 6;
  localparam int BEATS    = LINE_W / BEAT_W;
  localparam int CNT_W    = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FILL  = 2'd2,
    WRITE = 2'd3
  } refill_state_e;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_refill_buffer_if.sv
// Controller, memory and cache-array signals of the refill buffer.
// The slave side is the refill buffer; the master side is everything around it.
interface cache_refill_buffer_if;
  import cache_refill_buffer_pkg::*;

  logic                refill_req;
  logic [ADDR_W-1:0]   refill_addr;
  logic [INDEX_W-1:0]  refill_index;
  logic                busy;
  logic                refill_done;
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [ADDR_W-1:0]   mem_req_addr;
  logic                mem_rdata_valid;
  logic [BEAT_W-1:0]   mem_rdata;
  logic                cache_wr_en;
  logic [INDEX_W-1:0]  cache_wr_index;
  logic [LINE_W-1:0]   cache_wr_data;

  modport slave (
    input  refill_req, refill_addr, refill_index,
    input  mem_req_ready, mem_rdata_valid, mem_rdata,
    output busy, refill_done, mem_req_valid, mem_req_addr,
    output cache_wr_en, cache_wr_index, cache_wr_data
  );

  modport master (
    output refill_req, refill_addr, refill_index,
    output mem_req_ready, mem_rdata_valid, mem_rdata,
    input  busy, refill_done, mem_req_valid, mem_req_addr,
    input  cache_wr_en, cache_wr_index, cache_wr_data
  );

endinterface

// File: rtl/cache_refill_buffer.sv
// Line-fill stage: fetches one cache line as BEATS memory beats and writes it
// to the L1 data array in a single cycle.
//
// state | meaning
// IDLE  | waiting for refill_req
// REQ   | line read request presented to memory
// FILL  | collecting data beats into the line buffer
// WRITE | one-cycle cache array write, refill_done pulse
module cache_refill_buffer
  import cache_refill_buffer_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  cache_refill_buffer_if.slave bus
);

  refill_state_e      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [LINE_W-1:0]  line_buf_q, line_buf_d;
  logic [LINE_W-1:0]  wr_data_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [INDEX_W-1:0] index_q, wr_index_q;
  logic               accept;
  logic               beat_en;
  logic               last_beat;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    beat_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.refill_req) begin
          accept  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.mem_req_ready) state_d = FILL;
      end
      FILL: begin
        if (bus.mem_rdata_valid) begin
          beat_en = 1'b1;
          if (cnt_q == CNT_W'(BEATS - 1)) state_d = WRITE;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign last_beat = beat_en && (cnt_q == CNT_W'(BEATS - 1));

  always_comb begin
    line_buf_d = line_buf_q;
    if (beat_en) line_buf_d[cnt_q*BEAT_W +: BEAT_W] = bus.mem_rdata;
  end

  // The write-port copies are loaded with the completed line (including the
  // final beat) so they hold steady while the next line is assembled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      line_buf_q <= '0;
      wr_data_q  <= '0;
      addr_q     <= '0;
      index_q    <= '0;
      wr_index_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= line_align(bus.refill_addr);
        index_q <= bus.refill_index;
      end
      if (beat_en) begin
        cnt_q      <= cnt_q + 1'b1;
        line_buf_q <= line_buf_d;
      end
      if (last_beat) begin
        wr_data_q  <= line_buf_d;
        wr_index_q <= index_q;
      end
    end
  end

  assign bus.busy           = (state_q != IDLE);
  assign bus.mem_req_valid  = (state_q == REQ);
  assign bus.mem_req_addr   = addr_q;
  assign bus.cache_wr_en    = (state_q == WRITE);
  assign bus.refill_done    = (state_q == WRITE);
  assign bus.cache_wr_index = wr_index_q;
  assign bus.cache_wr_data  = wr_data_q;

endmodule

// File: tb/tb_cache_refill_buffer.sv
// Self-checking bench for cache_refill_buffer: random beats and timing checked
// against a line model assembled directly from the beat order.
module tb_cache_refill_buffer;
  import cache_refill_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_refill_buffer_if bus ();

  cache_refill_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  int           wr_cnt   = 0;
  int           done_err = 0;
  logic [5:0]   wr_idx;
  logic [511:0] wr_line;

  always @(negedge clk) begin
    if (bus.cache_wr_en === 1'b1) begin
      wr_cnt  = wr_cnt + 1;
      wr_idx  = bus.cache_wr_index;
      wr_line = bus.cache_wr_data;
    end
    if (rst === 1'b0 && bus.refill_done !== bus.cache_wr_en) done_err = done_err + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference line: beat k occupies bits [k*64 +: 64].
  function automatic logic [511:0] model_line(input logic [63:0] beats [8]);
    logic [511:0] l;
    l = '0;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = beats[k];
    return l;
  endfunction

  // Memory/controller driver. Called at a negedge; returns in the first IDLE cycle after WRITE.
  task automatic drive_refill(input logic [31:0] addr, input logic [5:0] idx,
                              input int stall, input int gap,
                              input bit stray_req, input bit busy_req,
                              input logic [63:0] beats [8],
                              output bit ok, output int lat, output bit stable,
                              output bit busy_ok, output logic [31:0] req_addr);
    int n, s, w;
    ok = 1; stable = 1; busy_ok = 1; lat = 0;
    bus.refill_req   = 1'b1;
    bus.refill_addr  = addr;
    bus.refill_index = idx;
    @(negedge clk); n = 1;
    bus.refill_req   = 1'b0;
    bus.refill_addr  = $urandom;
    bus.refill_index = 6'($urandom);
    req_addr = bus.mem_req_addr;
    s = 0;
    while (1) begin
      if (bus.busy !== 1'b1) busy_ok = 0;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== req_addr) stable = 0;
      if (s >= stall) break;
      s++;
      bus.mem_rdata_valid = stray_req;
      bus.mem_rdata       = {$urandom, $urandom};
      @(negedge clk); n++;
    end
    bus.mem_rdata_valid = 1'b0;
    bus.mem_req_ready   = 1'b1;
    @(negedge clk); n++;
    bus.mem_req_ready   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (bus.busy !== 1'b1) busy_ok = 0;
      bus.mem_rdata_valid = 1'b1;
      bus.mem_rdata       = beats[k];
      if (busy_req && k == 3) begin
        bus.refill_req   = 1'b1;
        bus.refill_addr  = 32'h0000_4000;
        bus.refill_index = ~idx;
      end
      @(negedge clk); n++;
      bus.mem_rdata_valid = 1'b0;
      bus.refill_req      = 1'b0;
      if (k < 7) begin
        for (int g = 0; g < gap; g++) begin
          if (bus.busy !== 1'b1) busy_ok = 0;
          @(negedge clk); n++;
        end
      end
    end
    w = 0;
    while (bus.cache_wr_en !== 1'b1 && w < 20) begin
      @(negedge clk); n++; w++;
    end
    if (bus.cache_wr_en !== 1'b1) ok = 0;
    if (bus.busy !== 1'b1) busy_ok = 0;
    lat = n;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.refill_req = 0; bus.refill_addr = '0; bus.refill_index = '0;
    bus.mem_req_ready = 0; bus.mem_rdata_valid = 0; bus.mem_rdata = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.busy, bus.refill_done, bus.mem_req_valid, bus.cache_wr_en} !== 4'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0000",
                      {bus.busy, bus.refill_done, bus.mem_req_valid, bus.cache_wr_en});
    end
    total++;
    if ({bus.mem_req_addr, bus.cache_wr_index} !== '0) begin
      bad++; $display("FAIL reset_addr_idx: got %h/%h want 0/0", bus.mem_req_addr, bus.cache_wr_index);
    end
    total++;
    if (bus.cache_wr_data !== '0) begin
      bad++; $display("FAIL reset_data: got %h want 0", bus.cache_wr_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [63:0] beats [8];
    logic [511:0] exp;
    logic [31:0] ra;
    bit ok, st, bo; int lat, c0;
    for (int k = 0; k < 8; k++) beats[k] = 64'h1111_1111_1111_1111 * (k + 1);
    exp = model_line(beats);
    c0 = wr_cnt;
    drive_refill(32'h0000_1234, 6'd5, 0, 0, 0, 0, beats, ok, lat, st, bo, ra);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_timeout: got no cache_wr_en want one"); end
    total++;
    if (ra !== 32'h0000_1200) begin bad++; $display("FAIL basic_req_addr: got %h want 00001200", ra); end
    total++;
    if (lat != 10) begin bad++; $display("FAIL basic_latency: got %0d want 10", lat); end
    total++;
    if (wr_cnt - c0 != 1) begin bad++; $display("FAIL basic_wr_count: got %0d want 1", wr_cnt - c0); end
    total++;
    if (wr_idx !== 6'd5) begin bad++; $display("FAIL basic_index: got %0d want 5", wr_idx); end
    total++;
    if (wr_line[63:0] !== 64'h1111_1111_1111_1111 || wr_line[511:448] !== 64'h8888_8888_8888_8888) begin
      bad++; $display("FAIL basic_ends: got %h/%h want 1111../8888..", wr_line[63:0], wr_line[511:448]);
    end
    total++;
    if (wr_line !== exp) begin bad++; $display("FAIL basic_line: got %h want %h", wr_line, exp); end
  endtask

  task automatic test_stall_gap();
    logic [63:0] beats [8];
    logic [31:0] ra;
    bit ok, st, bo; int lat, c0;
    for (int k = 0; k < 8; k++) beats[k] = 64'h1111_1111_1111_1111 * (k + 1);
    c0 = wr_cnt;
    drive_refill(32'h0000_1234, 6'd5, 4, 2, 0, 0, beats, ok, lat, st, bo, ra);
    total++;
    if (!ok || !st) begin bad++; $display("FAIL stall_stable: got ok=%0d stable=%0d want 1/1", ok, st); end
    total++;
    if (wr_cnt - c0 != 1) begin bad++; $display("FAIL stall_wr_count: got %0d want 1", wr_cnt - c0); end
    total++;
    if (wr_line !== model_line(beats) || wr_idx !== 6'd5) begin
      bad++; $display("FAIL stall_line: got %h idx %0d want %h idx 5", wr_line, wr_idx, model_line(beats));
    end
  endtask

  task automatic test_busy_req();
    logic [63:0] beats [8];
    logic [31:0] ra;
    logic [5:0] idx;
    bit ok, st, bo, quiet; int lat, c0;
    for (int k = 0; k < 8; k++) beats[k] = {$urandom, $urandom};
    idx = 6'($urandom);
    c0 = wr_cnt;
    drive_refill(32'h0000_8040, idx, 1, 1, 0, 1, beats, ok, lat, st, bo, ra);
    quiet = 1;
    for (int i = 0; i < 6; i++) begin
      if (bus.busy !== 1'b0 || bus.mem_req_valid !== 1'b0) quiet = 0;
      @(negedge clk);
    end
    total++;
    if (!bo) begin bad++; $display("FAIL busy_held: got busy drop want busy=1 until WRITE"); end
    total++;
    if (!quiet || wr_cnt - c0 != 1) begin
      bad++; $display("FAIL busy_ignored: got quiet=%0d writes=%0d want 1/1", quiet, wr_cnt - c0);
    end
    total++;
    if (wr_line !== model_line(beats) || wr_idx !== idx || ra !== 32'h0000_8040) begin
      bad++; $display("FAIL busy_line: got idx %0d addr %h want idx %0d addr 00008040", wr_idx, ra, idx);
    end
  endtask

  task automatic test_stray();
    logic [63:0] beats [8];
    logic [31:0] ra;
    bit ok, st, bo, idle_ok; int lat, c0;
    idle_ok = 1;
    c0 = wr_cnt;
    for (int i = 0; i < 3; i++) begin
      bus.mem_rdata_valid = 1'b1;
      bus.mem_rdata = {$urandom, $urandom};
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.mem_req_valid !== 1'b0 || bus.cache_wr_en !== 1'b0) idle_ok = 0;
    end
    bus.mem_rdata_valid = 1'b0;
    total++;
    if (!idle_ok) begin bad++; $display("FAIL stray_idle: got state change want none"); end
    for (int k = 0; k < 8; k++) beats[k] = {$urandom, $urandom};
    drive_refill(32'h0000_2000, 6'd17, 3, 0, 1, 0, beats, ok, lat, st, bo, ra);
    total++;
    if (!ok || wr_cnt - c0 != 1) begin bad++; $display("FAIL stray_wr_count: got %0d want 1", wr_cnt - c0); end
    total++;
    if (wr_line[63:0] !== beats[0] || wr_line !== model_line(beats)) begin
      bad++; $display("FAIL stray_line: got %h want %h", wr_line, model_line(beats));
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] beats [8];
    logic [31:0] ra;
    bit ok, st, bo; int lat, c0;
    c0 = wr_cnt;
    bus.refill_req = 1'b1; bus.refill_addr = 32'hABCD_0F00; bus.refill_index = 6'd20;
    @(negedge clk);
    bus.refill_req = 1'b0; bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.mem_rdata_valid = 1'b1; bus.mem_rdata = {$urandom, $urandom};
      @(negedge clk);
    end
    bus.mem_rdata_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.busy, bus.refill_done, bus.mem_req_valid, bus.cache_wr_en} !== 4'b0 ||
        bus.mem_req_addr !== '0 || bus.cache_wr_index !== '0 || bus.cache_wr_data !== '0) begin
      bad++; $display("FAIL rstmid_outputs: got busy=%b addr=%h idx=%0d want all 0",
                      bus.busy, bus.mem_req_addr, bus.cache_wr_index);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.mem_rdata_valid = 1'b1; bus.mem_rdata = {$urandom, $urandom};
      @(negedge clk);
    end
    bus.mem_rdata_valid = 1'b0;
    total++;
    if (bus.busy !== 1'b0 || wr_cnt != c0) begin
      bad++; $display("FAIL rstmid_aborted: got busy=%b writes=%0d want 0/0", bus.busy, wr_cnt - c0);
    end
    for (int k = 0; k < 8; k++) beats[k] = {$urandom, $urandom};
    drive_refill(32'h0001_0077, 6'd9, 0, 1, 0, 0, beats, ok, lat, st, bo, ra);
    total++;
    if (!ok || wr_idx !== 6'd9 || wr_line !== model_line(beats) || wr_cnt - c0 != 1) begin
      bad++; $display("FAIL rstmid_fresh: got idx %0d writes %0d want idx 9 writes 1", wr_idx, wr_cnt - c0);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] b0 [8];
    logic [63:0] b1 [8];
    logic [511:0] l0;
    logic [5:0] i0;
    logic [31:0] ra;
    bit ok0, ok1, st0, st1, bo; int lat0, lat1, c0;
    for (int k = 0; k < 8; k++) begin b0[k] = {$urandom, $urandom}; b1[k] = {$urandom, $urandom}; end
    c0 = wr_cnt;
    drive_refill(32'h0000_3FC0, 6'd63, 0, 0, 0, 0, b0, ok0, lat0, st0, bo, ra);
    l0 = wr_line; i0 = wr_idx;
    drive_refill(32'h0000_5000, 6'd0, 0, 0, 0, 0, b1, ok1, lat1, st1, bo, ra);
    total++;
    if (i0 !== 6'd63 || l0 !== model_line(b0)) begin
      bad++; $display("FAIL b2b_first: got idx %0d line %h want idx 63 line %h", i0, l0, model_line(b0));
    end
    total++;
    if (!ok1 || !st1 || lat1 != 10) begin
      bad++; $display("FAIL b2b_accept: got ok=%0d stable=%0d lat=%0d want 1/1/10", ok1, st1, lat1);
    end
    total++;
    if (wr_idx !== 6'd0 || wr_line !== model_line(b1) || wr_cnt - c0 != 2) begin
      bad++; $display("FAIL b2b_second: got idx %0d writes %0d want idx 0 writes 2", wr_idx, wr_cnt - c0);
    end
  endtask

  task automatic test_random();
    logic [63:0] beats [8];
    logic [31:0] addr, ra;
    logic [5:0] idx;
    bit ok, st, bo; int lat, c0;
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < 8; k++) beats[k] = {$urandom, $urandom};
      addr = $urandom;
      idx  = 6'($urandom);
      c0 = wr_cnt;
      drive_refill(addr, idx, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                   bit'($urandom_range(0, 1)), 0, beats, ok, lat, st, bo, ra);
      total++;
      if (!ok || !st || wr_cnt - c0 != 1 || ra !== {addr[31:6], 6'b0} || wr_idx !== idx ||
          wr_line !== model_line(beats)) begin
        bad++; $display("FAIL random_%0d: got addr %h idx %0d writes %0d want addr %h idx %0d writes 1",
                        it, ra, wr_idx, wr_cnt - c0, {addr[31:6], 6'b0}, idx);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall_gap();
    test_busy_req();
    test_stray();
    test_reset_mid();
    test_back_to_back();
    test_random();
    total++;
    if (done_err != 0) begin bad++; $display("FAIL done_coincident: got %0d mismatching cycles want 0", done_err); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_refill_buffer.md
Name: cache_refill_buffer

Overview:
- Line-fill stage directly upstream of the L1 cache data array.
- On a miss the controller hands it a block address and set index. The block requests the line from main memory, collects BEATS narrow data beats into a 512-bit line buffer, then issues one single-cycle write (index, data, write enable) to the cache array.
- The way is not selected here. The controller's LRU bit selects the way at the array.

Parameters:
- ADDR_W, 32, byte-address width.
- LINE_W, 512, cache block width in bits (64 bytes).
- BEAT_W, 64, memory read-data width per beat.
- INDEX_W, 6, set-index width (64 sets).
- BEATS, LINE_W/BEAT_W = 8, derived constant; not overridable.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- refill_req  in  1  controller: start refill (sampled in IDLE only).
- refill_addr  in  ADDR_W  miss address; low log2(LINE_W/8)=6 bits ignored.
- refill_index  in  INDEX_W  target set.
- busy  out  1  high in any state other than IDLE.
- refill_done  out  1  one-cycle pulse, coincident with cache_wr_en.
- mem_req_valid  out  1  line read request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  ADDR_W  line-aligned address (low 6 bits zero).
- mem_rdata_valid  in  1  one data beat present.
- mem_rdata  in  BEAT_W  beat data, ascending order, beat 0 = lowest bytes.
- cache_wr_en  out  1  write strobe to cache array.
- cache_wr_index  out  INDEX_W  set to write.
- cache_wr_data  out  LINE_W  assembled line.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Beat counter 0.
  - Line buffer, latched address and latched index cleared.
- State IDLE:
  - If refill_req=1, latch {refill_addr[ADDR_W-1:6], 6'b0} and refill_index, then go to REQ.
  - refill_req while busy=1 is ignored; it is not queued.
- State REQ:
  - mem_req_valid=1 and mem_req_addr=latched address, both held stable until the handshake.
  - The cycle with mem_req_valid&mem_req_ready completes the handshake. Go to FILL; mem_req_valid drops the next cycle.
- State FILL:
  - On each mem_rdata_valid, write mem_rdata to buffer[cnt*BEAT_W +: BEAT_W] and increment cnt (3 bits).
  - On the beat with cnt==BEATS-1, go to WRITE and return cnt to 0 (wrap).
  - Gaps between beats are allowed, with no timeout.
- State WRITE (exactly one cycle):
  - cache_wr_en=1, refill_done=1.
  - cache_wr_index=latched index, cache_wr_data=buffer.
  - Next state IDLE.
- cache_wr_index and cache_wr_data hold their last values outside WRITE. Consumers qualify with cache_wr_en only.
- mem_rdata_valid in IDLE, REQ or WRITE is ignored, with no buffer update.
- A refill_req arriving in the WRITE cycle is ignored. A refill_req arriving in the first IDLE cycle after WRITE is accepted. Minimum back-to-back spacing is therefore 1 idle cycle.
- Latency:
  - Request to first mem_req_valid: 1 cycle.
  - Last beat to cache_wr_en: 1 cycle.
  - Total with zero-wait memory: 1 (REQ) + 8 (FILL) + 1 (WRITE) = 10 cycles after acceptance.
- Reset asserted mid-operation (any state):
  - Immediately forces IDLE with all outputs 0.
  - The partial line is discarded and no cache write occurs.
  - Beats from the aborted transaction arriving after reset release are ignored while in IDLE.
- Illegal state encodings recover to IDLE.

Decomposition:
- Shared cache package:
  - LINE_W, INDEX_W and the offset width (6).
  - The refill state enum {IDLE, REQ, FILL, WRITE}.
  - The line-alignment function (clear the low offset bits).
- No sub-module needed. The beat-insert buffer is a single indexed part-select write inside this block.

Test Plan:
- Basic fill:
  - Stimulus: refill_req with addr 0x0000_1234 and index 5; mem_req_ready=1; 8 back-to-back beats 0x1111_1111_1111_1111 × k (k=1..8).
  - Required: mem_req_addr=0x0000_1200; cache_wr_en one cycle, 10 cycles after acceptance; cache_wr_data[63:0]=0x1111..11 and [511:448]=0x8888..88; cache_wr_index=5.
- Stalled handshake and gapped beats:
  - Stimulus: hold mem_req_ready=0 for 4 cycles; insert 2-cycle gaps between beats.
  - Required: mem_req_valid and mem_req_addr stable throughout the stall; exactly one cache_wr_en; line identical to the no-gap case.
- Request while busy:
  - Stimulus: second refill_req with addr 0x0000_4000 during FILL.
  - Required: ignored; only the first line is written; busy stays 1 until after WRITE.
- Stray beats:
  - Stimulus: mem_rdata_valid pulses in IDLE and REQ.
  - Required: no state change and no buffer corruption; the next fill still has beat 0 at bits [63:0].
- Reset mid-fill:
  - Stimulus: assert rst after 3 beats, then release; then perform a fresh refill to index 9.
  - Required: all outputs 0 immediately with no cache_wr_en from the aborted fill; the fresh refill writes index 9 with correct data.
- Back-to-back refills:
  - Stimulus: refill_req in the first IDLE cycle after refill_done, to index 63 and then index 0.
  - Required: two writes with correct indices; the beat counter wraps cleanly with no carry-over.
